ssp1_i2c_target: RTL and testbench
==================================

Name: ssp1_i2c_target

Overview:
- I2C target (responder) for the far end of the controller's open-drain I2C bus (SDA/SCL sensed, released or pulled low via active-low output enables).
- Used as an on-FPGA loopback/debug target and as a bench model: matches one 7-bit address and exposes a byte-addressed register port with auto-incrementing pointer.
- Supports write-pointer, burst write, burst read and repeated START.
- No clock stretching.

Parameters:
TargetAddress, 7'h42, 7-bit I2C address matched by this target
AddrWidth, 8, width of register pointer / o_addr (pointer wraps modulo 2^AddrWidth)
FilterLen, 3, consecutive identical synchronized samples required to accept a new SDA/SCL level (>=1)

Ports:
i_sys_clk  input  1  system clock; all logic on rising edge
i_rst_n  input  1  asynchronous active-low reset
i_sda  input  1  SDA pad input (from IOBUF O)
i_scl  input  1  SCL pad input (from IOBUF O)
o_sda_oe_n  output  1  0 = pull SDA low, 1 = release
o_scl_oe_n  output  1  constant 1 (no stretching)
o_addr  output  AddrWidth  current register pointer
o_wr_valid  output  1  one-cycle write strobe
o_wr_data  output  8  write byte, valid with o_wr_valid
i_rd_data  input  8  read byte for o_addr, sampled as below
o_busy  output  1  high while addressed (address match ACKed until STOP/START/NACK-abort)

Behaviour:
- Reset values: o_sda_oe_n=1, o_scl_oe_n=1, o_addr=0, o_wr_valid=0, o_wr_data=0, o_busy=0, state IDLE.
- Input path: 2-flop synchronizer per line, then filter: filtered level changes only after FilterLen consecutive equal samples. Line edges/conditions use filtered levels only; latency from pad to event = 2+FilterLen cycles.
- START: filtered SDA 1->0 while SCL=1. STOP: SDA 0->1 while SCL=1. Both are recognized in every state and take priority over bit events in the same cycle.
- Bits are sampled on SCL rising edge. SDA output changes only on SCL falling edge.
- States: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RACK, IGNORE.
- IDLE: on START go to ADDR, bit count=0.
- ADDR: shift 8 bits MSB first. On the 8th rise compare [7:1] to TargetAddress.
  - Mismatch: IGNORE.
  - Match: at next SCL fall set oe_n=0 and enter ADDR_ACK; o_busy=1.
- ADDR_ACK: at the SCL fall ending the 9th clock:
  - R/W=0: release SDA, go to PTR.
  - R/W=1: load shift reg from i_rd_data (sampled that cycle), drive MSB (oe_n = bit), go to RDATA.
- PTR: 8 bits; ACK as in ADDR_ACK. o_addr loads the byte at the SCL fall starting ACK. Then WDATA.
- WDATA: 8 bits. At the SCL fall starting ACK: o_wr_valid=1 for exactly one cycle with o_wr_data=byte at the current o_addr, and drive ACK. o_addr increments (wrap) the cycle after the strobe. At the fall ending ACK: release SDA, go to WDATA.
- RDATA: drive bits 6..0 on successive falls. After the 8th bit's fall, release SDA (oe_n=1) and go to RACK.
- RACK: sample SDA on the 9th rise.
  - 0 (ACK): increment o_addr immediately; at the next fall load i_rd_data for the new o_addr, drive MSB, go to RDATA. o_addr is stable >=1 cycle before sampling.
  - 1 (NACK): IGNORE, o_busy=0.
- IGNORE: SDA released; wait for START (-> ADDR) or STOP (-> IDLE).
- STOP in any state: release SDA, IDLE, o_busy=0; o_addr retained.
- START in any state (repeated START): release SDA immediately, go to ADDR, bit count=0, o_busy=0 until a new match; o_addr retained. This allows pointer-write then repeated-START read.
- START/STOP mid-byte discards the partial byte; no o_wr_valid.
- Asynchronous reset mid-transfer: all outputs return to reset values immediately; the bus is released.
- o_scl_oe_n is never driven low.

Test Plan:
- Reset: assert i_rst_n=0 mid-ACK (oe_n=0) -> o_sda_oe_n=1 in the same cycle, o_addr=0, o_busy=0.
- Write burst: START, 0x84 (addr 0x42 W), 0x10, 0xA5, 0x5A, STOP -> target ACKs all 4 bytes. o_wr_valid pulses twice, exactly 1 cycle each: (o_addr 0x10, data 0xA5), then (0x11, 0x5A). Final o_addr=0x12, o_busy=0 after STOP.
- Address mismatch: START, 0x86, 0x10, STOP -> SDA never pulled low, no o_wr_valid, o_addr unchanged.
- Repeated-START read: START 0x84 0x20, Sr 0x85, master ACK, ACK, NACK, STOP, with bench returning i_rd_data=o_addr^0xFF -> bytes read 0xDF, 0xDE, 0xDD. Final o_addr=0x22 and SDA released before the 9th clock of each byte.
- Pointer wrap: write pointer 0xFF, data 0x11, 0x22 -> strobes at o_addr 0xFF then 0x00.
- Glitch/abort: 1-cycle SCL glitch (< FilterLen) during WDATA causes no extra bit. START after 4 data bits discards the partial byte (no strobe) and decodes the next 0x84 normally.

Source files
------------

// File: rtl/ssp1_i2c_target.sv
// ssp1_i2c_target: 7-bit-address I2C target with an auto-incrementing byte register port.
// Rev 1.0 - initial release.
`default_nettype none
`timescale 1ns/1ps

module ssp1_i2c_target #(
   parameter logic [6:0] TargetAddress = 7'h42,
   parameter int         AddrWidth     = 8,
   parameter int         FilterLen     = 3
) (
   input  logic                 i_sys_clk,
   input  logic                 i_rst_n,
   input  logic                 i_sda,
   input  logic                 i_scl,
   output logic                 o_sda_oe_n,
   output logic                 o_scl_oe_n,
   output logic [AddrWidth-1:0] o_addr,
   output logic                 o_wr_valid,
   output logic [7:0]           o_wr_data,
   input  logic [7:0]           i_rd_data,
   output logic                 o_busy
);

   localparam int CntW = (FilterLen > 1) ? $clog2(FilterLen) : 1;
   localparam logic [CntW-1:0] CntMax = CntW'(FilterLen - 1);

   typedef enum logic [3:0] {
      IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RACK, IGNORE
   } state_t;

   // Index 0 = SDA, index 1 = SCL.
   logic [1:0]      s1_q, s2_q, filt_q, prev_q;
   logic [CntW-1:0] cnt_q [2];

   always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         s1_q     <= 2'b11;
         s2_q     <= 2'b11;
         filt_q   <= 2'b11;
         prev_q   <= 2'b11;
         cnt_q[0] <= '0;
         cnt_q[1] <= '0;
      end else begin
         s1_q   <= {i_scl, i_sda};
         s2_q   <= s1_q;
         prev_q <= filt_q;
         for (int k = 0; k < 2; k++) begin
            if (s2_q[k] == filt_q[k]) begin
               cnt_q[k] <= '0;
            end else if (cnt_q[k] == CntMax) begin
               filt_q[k] <= s2_q[k];
               cnt_q[k]  <= '0;
            end else begin
               cnt_q[k] <= cnt_q[k] + 1'b1;
            end
         end
      end
   end

   logic sda_f, start_ev, stop_ev, rise_ev, fall_ev;
   assign sda_f    = filt_q[0];
   assign start_ev =  prev_q[0] & ~filt_q[0] & prev_q[1] & filt_q[1];
   assign stop_ev  = ~prev_q[0] &  filt_q[0] & prev_q[1] & filt_q[1];
   assign rise_ev  = ~prev_q[1] &  filt_q[1];
   assign fall_ev  =  prev_q[1] & ~filt_q[1];

   state_t               state_q, state_d;
   logic [3:0]           bitcnt_q, bitcnt_d;
   logic [7:0]           shreg_q, shreg_d;
   logic                 oe_q, oe_d;
   logic [AddrWidth-1:0] addr_q, addr_d;
   logic                 wrv_q, wrv_d;
   logic [7:0]           wrd_q, wrd_d;
   logic                 busy_q, busy_d;
   logic [7:0]           rx_byte;

   always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q  <= IDLE;
         bitcnt_q <= '0;
         shreg_q  <= '0;
         oe_q     <= 1'b1;
         addr_q   <= '0;
         wrv_q    <= 1'b0;
         wrd_q    <= '0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         bitcnt_q <= bitcnt_d;
         shreg_q  <= shreg_d;
         oe_q     <= oe_d;
         addr_q   <= addr_d;
         wrv_q    <= wrv_d;
         wrd_q    <= wrd_d;
         busy_q   <= busy_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      bitcnt_d = bitcnt_q;
      shreg_d  = shreg_q;
      oe_d     = oe_q;
      addr_d   = addr_q;
      wrv_d    = 1'b0;
      wrd_d    = wrd_q;
      busy_d   = busy_q;
      rx_byte  = {shreg_q[6:0], sda_f};

      // The pointer steps the cycle after each write strobe, whatever the bus does next.
      if (wrv_q) addr_d = addr_q + 1'b1;

      if (stop_ev) begin
         state_d = IDLE;
         oe_d    = 1'b1;
         busy_d  = 1'b0;
      end else if (start_ev) begin
         state_d  = ADDR;
         bitcnt_d = '0;
         oe_d     = 1'b1;
         busy_d   = 1'b0;
      end else begin
         case (state_q)
            IDLE, IGNORE: oe_d = 1'b1;
            ADDR, PTR, WDATA: begin
               if (rise_ev && bitcnt_q < 4'd8) begin
                  shreg_d  = rx_byte;
                  bitcnt_d = bitcnt_q + 4'd1;
                  if (state_q == ADDR && bitcnt_q == 4'd7 && rx_byte[7:1] != TargetAddress)
                     state_d = IGNORE;
               end else if (fall_ev && bitcnt_q == 4'd8) begin
                  oe_d = 1'b0;
                  case (state_q)
                     ADDR: begin
                        state_d = ADDR_ACK;
                        busy_d  = 1'b1;
                     end
                     PTR: begin
                        addr_d  = AddrWidth'(shreg_q);
                        state_d = PTR_ACK;
                     end
                     default: begin
                        wrv_d   = 1'b1;
                        wrd_d   = shreg_q;
                        state_d = WDATA_ACK;
                     end
                  endcase
               end
            end
            ADDR_ACK: begin
               if (fall_ev) begin
                  if (shreg_q[0]) begin
                     shreg_d  = i_rd_data;
                     oe_d     = i_rd_data[7];
                     bitcnt_d = 4'd1;
                     state_d  = RDATA;
                  end else begin
                     oe_d     = 1'b1;
                     bitcnt_d = '0;
                     state_d  = PTR;
                  end
               end
            end
            PTR_ACK, WDATA_ACK: begin
               if (fall_ev) begin
                  oe_d     = 1'b1;
                  bitcnt_d = '0;
                  state_d  = WDATA;
               end
            end
            RDATA: begin
               if (fall_ev) begin
                  if (bitcnt_q == 4'd8) begin
                     oe_d    = 1'b1;
                     state_d = RACK;
                  end else begin
                     shreg_d  = {shreg_q[6:0], 1'b0};
                     oe_d     = shreg_q[6];
                     bitcnt_d = bitcnt_q + 4'd1;
                  end
               end
            end
            RACK: begin
               // A fall seen here can only follow an ACKed 9th clock; a NACK has already left.
               if (rise_ev) begin
                  if (sda_f) begin
                     state_d = IGNORE;
                     busy_d  = 1'b0;
                  end else begin
                     addr_d = addr_q + 1'b1;
                  end
               end else if (fall_ev) begin
                  shreg_d  = i_rd_data;
                  oe_d     = i_rd_data[7];
                  bitcnt_d = 4'd1;
                  state_d  = RDATA;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   assign o_sda_oe_n = oe_q;
   assign o_scl_oe_n = 1'b1;
   assign o_addr     = addr_q;
   assign o_wr_valid = wrv_q;
   assign o_wr_data  = wrd_q;
   assign o_busy     = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_ssp1_i2c_target.sv
// tb_ssp1_i2c_target: bus-level directed bench with a write-strobe scoreboard.
// Rev 1.0 - initial release.
`default_nettype none
`timescale 1ns/1ps

module tb_ssp1_i2c_target;

   localparam int Q = 12;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       m_sda = 1'b1;
   logic       m_scl = 1'b1;
   logic       sda_line, scl_line;
   logic       dut_sda_oe_n, dut_scl_oe_n, dut_wr_valid, dut_busy;
   logic [7:0] dut_addr, dut_wr_data, rd_data;

   always #5 clk = ~clk;

   assign sda_line = m_sda & dut_sda_oe_n;
   assign scl_line = m_scl & dut_scl_oe_n;
   assign rd_data  = dut_addr ^ 8'hFF;

   ssp1_i2c_target dut (
      .i_sys_clk (clk),
      .i_rst_n   (rst_n),
      .i_sda     (sda_line),
      .i_scl     (scl_line),
      .o_sda_oe_n(dut_sda_oe_n),
      .o_scl_oe_n(dut_scl_oe_n),
      .o_addr    (dut_addr),
      .o_wr_valid(dut_wr_valid),
      .o_wr_data (dut_wr_data),
      .i_rd_data (rd_data),
      .o_busy    (dut_busy)
   );

   int total = 0;
   int bad   = 0;
   int pull_cnt = 0;

   typedef struct packed {
      logic [7:0] a;
      logic [7:0] d;
   } wr_t;
   wr_t exp_wr[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Scoreboard monitor: every strobe must match the next queued (addr, data).
   always @(negedge clk) begin
      wr_t e;
      if (!dut_sda_oe_n) pull_cnt++;
      if (rst_n && dut_wr_valid) begin
         if (exp_wr.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_strobe: got addr=%0h data=%0h expected none", dut_addr, dut_wr_data);
         end else begin
            e = exp_wr.pop_front();
            chk("strobe_addr", {24'd0, dut_addr}, {24'd0, e.a});
            chk("strobe_data", {24'd0, dut_wr_data}, {24'd0, e.d});
         end
      end
   end

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wbit(input logic b);
      m_sda = b;
      wait_clk(Q);
      m_scl = 1'b1;
      wait_clk(2 * Q);
      m_scl = 1'b0;
      wait_clk(Q);
   endtask

   task automatic wbit_glitch(input logic b);
      m_sda = b;
      wait_clk(Q);
      m_scl = 1'b1;
      wait_clk(Q);
      m_scl = 1'b0;
      wait_clk(1);
      m_scl = 1'b1;
      wait_clk(Q);
      m_scl = 1'b0;
      wait_clk(Q);
   endtask

   task automatic rbit(output logic b);
      m_sda = 1'b1;
      wait_clk(Q);
      m_scl = 1'b1;
      wait_clk(Q);
      b = sda_line;
      wait_clk(Q);
      m_scl = 1'b0;
      wait_clk(Q);
   endtask

   task automatic start_c();
      m_sda = 1'b1;
      wait_clk(Q);
      m_scl = 1'b1;
      wait_clk(Q);
      m_sda = 1'b0;
      wait_clk(Q);
      m_scl = 1'b0;
      wait_clk(Q);
   endtask

   task automatic stop_c();
      m_sda = 1'b0;
      wait_clk(Q);
      m_scl = 1'b1;
      wait_clk(Q);
      m_sda = 1'b1;
      wait_clk(2 * Q);
   endtask

   task automatic wbyte(input logic [7:0] b, input logic exp_bit, input string name);
      logic a;
      for (int i = 7; i >= 0; i--) wbit(b[i]);
      rbit(a);
      chk({name, "_ack"}, {31'd0, a}, {31'd0, exp_bit});
   endtask

   task automatic rbyte(input logic [7:0] exp, input logic m_ack, input string name);
      logic [7:0] v;
      logic       b;
      v = '0;
      for (int i = 0; i < 8; i++) begin
         rbit(b);
         v = {v[6:0], b};
      end
      chk(name, {24'd0, v}, {24'd0, exp});
      chk({name, "_released"}, {31'd0, dut_sda_oe_n}, 32'd1);
      wbit(~m_ack);
   endtask

   initial begin
      int p0;
      wait_clk(5);
      chk("rst_sda_oe_n", {31'd0, dut_sda_oe_n}, 32'd1);
      chk("rst_scl_oe_n", {31'd0, dut_scl_oe_n}, 32'd1);
      chk("rst_addr", {24'd0, dut_addr}, 32'd0);
      chk("rst_wr_valid", {31'd0, dut_wr_valid}, 32'd0);
      chk("rst_wr_data", {24'd0, dut_wr_data}, 32'd0);
      chk("rst_busy", {31'd0, dut_busy}, 32'd0);
      rst_n = 1'b1;
      wait_clk(20);

      // Burst write through pointer 0x10
      start_c();
      wbyte(8'h84, 1'b0, "wr_addr");
      chk("wr_busy", {31'd0, dut_busy}, 32'd1);
      wbyte(8'h10, 1'b0, "wr_ptr");
      exp_wr.push_back('{a: 8'h10, d: 8'hA5});
      wbyte(8'hA5, 1'b0, "wr_d0");
      exp_wr.push_back('{a: 8'h11, d: 8'h5A});
      wbyte(8'h5A, 1'b0, "wr_d1");
      stop_c();
      chk("wr_final_addr", {24'd0, dut_addr}, 32'h12);
      chk("wr_busy_after_stop", {31'd0, dut_busy}, 32'd0);

      // Address mismatch
      p0 = pull_cnt;
      start_c();
      wbyte(8'h86, 1'b1, "mm_addr");
      wbyte(8'h10, 1'b1, "mm_ptr");
      stop_c();
      chk("mm_no_pull", pull_cnt, p0);
      chk("mm_addr_kept", {24'd0, dut_addr}, 32'h12);

      // Pointer write then repeated-START read
      start_c();
      wbyte(8'h84, 1'b0, "rd_waddr");
      wbyte(8'h20, 1'b0, "rd_ptr");
      start_c();
      wbyte(8'h85, 1'b0, "rd_raddr");
      rbyte(8'hDF, 1'b1, "rd_b0");
      rbyte(8'hDE, 1'b1, "rd_b1");
      rbyte(8'hDD, 1'b0, "rd_b2");
      chk("rd_busy_after_nack", {31'd0, dut_busy}, 32'd0);
      stop_c();
      chk("rd_final_addr", {24'd0, dut_addr}, 32'h22);

      // Pointer wrap
      start_c();
      wbyte(8'h84, 1'b0, "wrap_addr");
      wbyte(8'hFF, 1'b0, "wrap_ptr");
      exp_wr.push_back('{a: 8'hFF, d: 8'h11});
      wbyte(8'h11, 1'b0, "wrap_d0");
      exp_wr.push_back('{a: 8'h00, d: 8'h22});
      wbyte(8'h22, 1'b0, "wrap_d1");
      stop_c();
      chk("wrap_final_addr", {24'd0, dut_addr}, 32'h01);

      // SCL glitch inside a data byte, then abort a partial byte with Sr
      begin
         logic       a;
         logic [7:0] gb;
         gb = 8'h3C;
         start_c();
         wbyte(8'h84, 1'b0, "gl_addr");
         wbyte(8'h30, 1'b0, "gl_ptr");
         exp_wr.push_back('{a: 8'h30, d: 8'h3C});
         for (int i = 7; i >= 0; i--) begin
            if (i == 3) wbit_glitch(gb[i]);
            else        wbit(gb[i]);
         end
         rbit(a);
         chk("gl_data_ack", {31'd0, a}, 32'd0);
         wbit(1'b1);
         wbit(1'b0);
         wbit(1'b1);
         wbit(1'b0);
         start_c();
         wbyte(8'h84, 1'b0, "ab_addr");
         wbyte(8'h40, 1'b0, "ab_ptr");
         exp_wr.push_back('{a: 8'h40, d: 8'h77});
         wbyte(8'h77, 1'b0, "ab_d0");
         stop_c();
         chk("ab_final_addr", {24'd0, dut_addr}, 32'h41);
      end

      // Asynchronous reset while the address ACK is being driven
      start_c();
      for (int i = 7; i >= 0; i--) wbit(p0 >= 0 ? 1'((8'h84 >> i) & 1) : 1'b0);
      m_sda = 1'b1;
      wait_clk(Q / 2);
      chk("mid_ack_driven", {31'd0, dut_sda_oe_n}, 32'd0);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_sda_oe_n", {31'd0, dut_sda_oe_n}, 32'd1);
      chk("arst_addr", {24'd0, dut_addr}, 32'd0);
      chk("arst_busy", {31'd0, dut_busy}, 32'd0);
      chk("arst_wr_valid", {31'd0, dut_wr_valid}, 32'd0);
      wait_clk(5);
      rst_n = 1'b1;
      wait_clk(10);
      stop_c();

      chk("scoreboard_drained", exp_wr.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
